// File: rtl/systolic_ctrl.sv
`timescale 1ns/1ps
// Sequencer for an NxN systolic MAC array: CLEAR, K feed cycles, skewed drain, DONE.
// Optional performance counters are built in when SYS_CTRL_PERF_EN is defined.
module systolic_ctrl #(
    parameter int N   = 2,
    parameter int K_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    input  logic                    abort,
    output logic                    busy,
    output logic                    feed_req,
    output logic                    data_valid,
    output logic [N-1:0][N-1:0]     en_mult,
    output logic [N-1:0][N-1:0]     clr_mult,
    output logic [N-1:0][N-1:0]     en_accum,
    output logic [N-1:0][N-1:0]     clr_accum,
    output logic [N-1:0][N-1:0]     accum_start,
    output logic                    done,
    output logic                    result_valid,
`ifdef SYS_CTRL_PERF_EN
    output logic [2:0]              state_dbg,
    output logic [15:0]             perf_jobs,
    output logic [31:0]             perf_busy_cyc
`else
    output logic [2:0]              state_dbg
`endif
);

    localparam int T_W = K_W + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [T_W-1:0] T_ONE     = T_W'(1);
    localparam logic [T_W-1:0] DRAIN_END = T_W'(2 * N - 2);

    logic [2:0]     state;
    logic [2:0]     state_n;
    logic [T_W-1:0] t;
    logic [T_W-1:0] t_n;
    logic [K_W-1:0] k_reg;
    logic [T_W-1:0] k_ext;
    logic           accept;
    logic           cancel;
    logic           active_n;

    logic [N-1:0][N-1:0] en_mult_n;
    logic [N-1:0][N-1:0] en_accum_n;
    logic [N-1:0][N-1:0] accum_start_n;

    assign k_ext     = {2'b00, k_reg};
    assign accept    = (state == S_IDLE) && start && !abort && (k_len != '0);
    assign cancel    = abort && (state != S_IDLE);
    assign state_dbg = state;

    // t counts from the first FEED cycle and keeps running through DRAIN.
    always_comb begin
        state_n = state;
        t_n     = '0;
        case (state)
            S_IDLE: begin
                if (accept) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                state_n = cancel ? S_IDLE : S_FEED;
            end
            S_FEED: begin
                if (cancel) begin
                    state_n = S_IDLE;
                end else begin
                    t_n = t + T_ONE;
                    if (t == k_ext - T_ONE) state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cancel) begin
                    state_n = S_IDLE;
                end else begin
                    t_n = t + T_ONE;
                    if (t == k_ext + DRAIN_END) state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign active_n = (state_n == S_FEED) || (state_n == S_DRAIN);

    // PE(i,j) sees operand k at t = i+j+k; its accumulator lags the multiplier by one cycle.
    always_comb begin
        logic [T_W-1:0] off;
        off           = '0;
        en_mult_n     = '0;
        en_accum_n    = '0;
        accum_start_n = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                off = T_W'(i + j);
                if (active_n) begin
                    en_mult_n[i][j]     = (t_n >= off) && (t_n < off + k_ext);
                    en_accum_n[i][j]    = (t_n > off) && (t_n <= off + k_ext);
                    accum_start_n[i][j] = (t_n == off + T_ONE);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            t            <= '0;
            k_reg        <= '0;
            busy         <= 1'b0;
            feed_req     <= 1'b0;
            data_valid   <= 1'b0;
            en_mult      <= '0;
            clr_mult     <= '0;
            en_accum     <= '0;
            clr_accum    <= '0;
            accum_start  <= '0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state       <= state_n;
            t           <= t_n;
            if (accept) k_reg <= k_len;
            busy        <= (state_n != S_IDLE);
            feed_req    <= (state_n == S_FEED);
            data_valid  <= (state_n == S_FEED);
            clr_mult    <= (state_n == S_CLEAR) ? '1 : '0;
            clr_accum   <= (state_n == S_CLEAR) ? '1 : '0;
            en_mult     <= en_mult_n;
            en_accum    <= en_accum_n;
            accum_start <= accum_start_n;
            done        <= (state_n == S_DONE);
            if (accept || cancel) begin
                result_valid <= 1'b0;
            end else if (state_n == S_DONE) begin
                result_valid <= 1'b1;
            end
        end
    end

`ifdef SYS_CTRL_PERF_EN
    // Saturating counters; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_jobs     <= '0;
            perf_busy_cyc <= '0;
        end else begin
            if (done && (perf_jobs != '1)) perf_jobs <= perf_jobs + 16'd1;
            if (busy && (perf_busy_cyc != '1)) perf_busy_cyc <= perf_busy_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for systolic_ctrl: per-cycle control vectors plus a behavioural
// PE array driven by the DUT's enables, whose results are compared to a plain matrix product.
module tb_systolic_ctrl;

    localparam int N    = 2;
    localparam int K_W  = 8;
    localparam int W    = 4 + 5 * N * N;
    localparam int KMAX = 255;

    logic                clk;
    logic                rst;
    logic                start;
    logic [K_W-1:0]      k_len;
    logic                abort;
    logic                busy;
    logic                feed_req;
    logic                data_valid;
    logic [N-1:0][N-1:0] en_mult;
    logic [N-1:0][N-1:0] clr_mult;
    logic [N-1:0][N-1:0] en_accum;
    logic [N-1:0][N-1:0] clr_accum;
    logic [N-1:0][N-1:0] accum_start;
    logic                done;
    logic                result_valid;
    logic [2:0]          state_dbg;
`ifdef SYS_CTRL_PERF_EN
    logic [15:0]         perf_jobs;
    logic [31:0]         perf_busy_cyc;
`endif

    systolic_ctrl #(.N(N), .K_W(K_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .abort        (abort),
        .busy         (busy),
        .feed_req     (feed_req),
        .data_valid   (data_valid),
        .en_mult      (en_mult),
        .clr_mult     (clr_mult),
        .en_accum     (en_accum),
        .clr_accum    (clr_accum),
        .accum_start  (accum_start),
        .done         (done),
        .result_valid (result_valid),
`ifdef SYS_CTRL_PERF_EN
        .perf_jobs    (perf_jobs),
        .perf_busy_cyc(perf_busy_cyc),
`endif
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    int cur_a[N][KMAX];
    int cur_w[KMAX][N];
    int cur_exp[N][N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Expected output vector for cycle c of a job (c=0 is the clear cycle, t=c-1 afterwards).
    function automatic logic [W-1:0] exp_vec(input int k, input int c);
        logic [N-1:0][N-1:0] cm, em, ea, as;
        logic d, dv;
        int t, o;
        cm = '0; em = '0; ea = '0; as = '0; d = 1'b0; dv = 1'b0;
        if (c == 0) begin
            cm = '1;
        end else begin
            t  = c - 1;
            dv = (t < k);
            d  = (t == k + 2 * N - 1);
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    o = i + j;
                    em[i][j] = (t >= o) && (t <= o + k - 1);
                    ea[i][j] = (t >= o + 1) && (t <= o + k);
                    as[i][j] = (t == o + 1);
                end
            end
        end
        return {d, d, dv, dv, cm, cm, em, ea, as};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input int k, input int ncyc);
        int n;
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < KMAX; kk++) cur_a[i][kk] = $urandom_range(0, 255);
        for (int kk = 0; kk < KMAX; kk++)
            for (int j = 0; j < N; j++) cur_w[kk][j] = $urandom_range(0, 255);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                cur_exp[i][j] = 0;
                for (int kk = 0; kk < k; kk++) cur_exp[i][j] += cur_a[i][kk] * cur_w[kk][j];
            end
        if (k != 0) begin
            n = (ncyc < 0) ? (k + 2 * N + 1) : ncyc;
            for (int c = 0; c < n; c++) exp_q.push_back(exp_vec(k, c));
        end
        start = 1'b1;
        k_len = K_W'(k);
        @(posedge clk); #1;
        start = 1'b0;
        k_len = K_W'($urandom);
    endtask

    // ab: cycle index at which abort is raised (-1 none); noise: cycle of a stray start (-1 none).
    task automatic run_job(input int k, input int ab, input int noise);
        issue(k, (ab < 0) ? -1 : ab + 1);
        for (int c = 0; c <= k + 2 * N; c++) begin
            if (c == ab) abort = 1'b1;
            if (c == noise) begin
                start = 1'b1;
                k_len = K_W'($urandom_range(1, 255));
            end
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            if (c == ab) break;
        end
        check("busy_after_job", {63'd0, busy}, 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- monitor ----------------
    logic rv_exp = 1'b0;
    int   jobs_m = 0;
    int   busy_m = 0;
    int   tcnt   = 0;
    int   acc[N][N];
    int   prod[N][N];

    always @(negedge clk) begin
        logic [W-1:0] e;
        int kk;
        if (rst) begin
            rv_exp = 1'b0;
            jobs_m = 0;
            busy_m = 0;
        end else if (busy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_busy: actual=1 expected=0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("outputs", {result_valid, done, data_valid, feed_req, clr_mult, clr_accum,
                                  en_mult, en_accum, accum_start}, e);
                rv_exp = e[W-1];
                busy_m++;
                if (e[W-2]) jobs_m++;
            end
            if (|clr_mult) begin
                tcnt = 0;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        if (clr_mult[i][j]) prod[i][j] = 0;
                        if (clr_accum[i][j]) acc[i][j] = 0;
                    end
            end else begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        if (en_accum[i][j]) acc[i][j] = accum_start[i][j] ? prod[i][j] : acc[i][j] + prod[i][j];
                        if (en_mult[i][j]) begin
                            kk = tcnt - i - j;
                            prod[i][j] = (kk >= 0 && kk < KMAX) ? cur_a[i][kk] * cur_w[kk][j] : -1;
                        end
                    end
                tcnt++;
            end
            if (done) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        check("c_out", 64'(acc[i][j]), 64'(cur_exp[i][j]));
            end
        end else begin
            check("idle_outputs", {done, data_valid, feed_req, clr_mult, clr_accum, en_mult,
                                   en_accum, accum_start}, 64'd0);
            check("result_valid_idle", {63'd0, result_valid}, {63'd0, rv_exp});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k, r, ab, noise;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        idle_cycles(2);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_grids", {done, result_valid, data_valid, feed_req, clr_mult, clr_accum,
                              en_mult, en_accum, accum_start}, 64'd0);
        rst = 1'b0;
        idle_cycles(2);

        // K=4 with a stray start at t2, then a job started the cycle after done
        run_job(4, -1, 3);
        run_job(3, -1, -1);

        // zero-length request is ignored
        start = 1'b1; k_len = '0;
        idle_cycles(1);
        start = 1'b0;
        idle_cycles(2);
        check("zero_len_busy", {63'd0, busy}, 64'd0);

        // abort at t3, then a K=2 job
        run_job(4, 4, -1);
        check("abort_rv", {63'd0, result_valid}, 64'd0);
        run_job(2, -1, -1);
        check("rv_after_done", {63'd0, result_valid}, 64'd1);

        // abort in idle leaves result_valid alone
        abort = 1'b1;
        idle_cycles(1);
        abort = 1'b0;
        check("rv_after_idle_abort", {63'd0, result_valid}, 64'd1);

        // start together with abort in idle: abort wins
        start = 1'b1; abort = 1'b1; k_len = 8'd3;
        idle_cycles(1);
        start = 1'b0; abort = 1'b0;
        idle_cycles(2);
        check("start_abort_busy", {63'd0, busy}, 64'd0);

        // asynchronous reset at t1 of a K=4 job
        issue(4, -1);
        idle_cycles(2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_outputs", {done, result_valid, data_valid, feed_req, clr_mult, clr_accum,
                                    en_mult, en_accum, accum_start}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(1);
        run_job(1, -1, -1);

        // longest job
        run_job(KMAX, -1, -1);

        // randomized jobs
        for (int n = 0; n < 30; n++) begin
            k  = $urandom_range(1, 12);
            r  = $urandom_range(0, 3);
            ab = -1;
            noise = -1;
            if (r == 0) ab = $urandom_range(0, k + 2 * N - 1);
            else if (r == 1) noise = $urandom_range(0, k + 2 * N);
            run_job(k, ab, noise);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

`ifdef SYS_CTRL_PERF_EN
        check("perf_jobs_model", 64'(perf_jobs), 64'(jobs_m));
        check("perf_busy_model", 64'(perf_busy_cyc), 64'(busy_m));
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(1);
        run_job(4, -1, -1);
        run_job(4, -1, -1);
        idle_cycles(2);
        check("perf_jobs_two", 64'(perf_jobs), 64'd2);
        check("perf_busy_two", 64'(perf_busy_cyc), 64'd18);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
